conv_fmap_reader: RTL and testbench

CONV_FMAP_READER -- requirements
Module: conv_fmap_reader

---
 rtl/conv_fmap_pkg.sv | 40 ++++
 rtl/fmap_fifo.sv | 78 +++++++
 rtl/conv_fmap_reader.sv | 173 +++++++++++++++++
 tb/tb_conv_fmap_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fmap_pkg.sv
// Shared types and constants for the conv feature-map reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, word/nibble geometry, activation ceiling and
// the default run length (128 channels x 8 rows x 8 columns).
package conv_fmap_pkg;

    // Upstream BRAM words hold eight 4-bit activations, nibble 0 in bits 31:28.
    localparam int NIBBLES_PER_WORD = 8;

    // Largest legal activation value produced by the upstream layer.
    localparam int ACT_MAX = 6;

    // Default number of activations streamed per run.
    localparam int N_ELEMS_DEFAULT = 8192;

    // Stream payload geometry: 4-bit activation plus 32-bit element index.
    localparam int DATA_W  = 4;
    localparam int IDX_W   = 32;
    localparam int ENTRY_W = DATA_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_SRC = 3'd1,
        WAIT_SRC  = 3'd2,
        ISSUE     = 3'd3,
        CAPTURE   = 3'd4,
        DRAIN     = 3'd5,
        DONE_ST   = 3'd6
    } state_t;

    // Saturate a raw nibble to the legal activation range.
    function automatic logic [DATA_W-1:0] act_clamp(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] lim;
        lim = DATA_W'(ACT_MAX);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fmap_fifo.sv
// Small first-word-fall-through FIFO for the feature-map output stream.
// Latency: a write is visible at the head one cycle later; reads are combinational from the head.
// Backpressure: a write is accepted when not full, or when full and a read happens in the same cycle.
//
// Ports:
//   clk_i, reset_i       clock and synchronous active-high reset
//   wr_en_i, wr_dat_i    write request and entry
//   rd_en_i              consumer pops the head (ignored while empty)
//   rd_dat_o, rd_vld_o   head entry and not-empty flag
//   count_o              current occupancy 0..DEPTH
module fmap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_dat_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_dat_o,
    output logic                       rd_vld_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    logic empty;
    logic full;
    logic do_rd;
    logic do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A read frees the slot this same cycle, so a full FIFO can still take
    // a write when the head is being popped.
    assign do_rd = rd_en_i && !empty;
    assign do_wr = wr_en_i && (!full || do_rd);

    // Storage needs no reset: entries are only visible when count_q > 0.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_dat_o = mem_q[rd_ptr_q];
    assign rd_vld_o = !empty;
    assign count_o  = count_q;

endmodule

// File: rtl/conv_fmap_reader.sv
// Streams one conv layer's 4-bit activation map out of its BRAM as an indexed valid/ready stream.
// Latency: src_done at cycle t gives the first element (m_idx 0) at cycle t+3; at most one element per 2 cycles.
// Backpressure: m_ready low fills the output FIFO, and the reader then stalls in ISSUE with its address held.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start / busy / done         run request, run in progress, end-of-run pulse
//   src_start / src_done        handshake with the upstream conv layer
//   src_read_addr               nibble address into the upstream BRAM (registered)
//   src_read_data               nibble selected by the live address from last cycle's word
//   m_valid/m_ready/m_data/m_idx/m_last   output stream
module conv_fmap_reader
    import conv_fmap_pkg::*;
#(
    parameter int N_ELEMS    = N_ELEMS_DEFAULT,
    // Must be a power of two and at least 2.
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        src_start,
    input  logic        src_done,
    output logic [31:0] src_read_addr,
    input  logic [3:0]  src_read_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_data,
    output logic [31:0] m_idx,
    output logic        m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

    // Reader FSM and its registered outputs.
    state_t            state_q;
    logic [IDX_W-1:0]  rd_ptr_q;
    logic [31:0]       src_read_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              src_start_q;

    // FIFO side.
    logic              fifo_wr;
    logic [ENTRY_W-1:0] fifo_wr_dat;
    logic [ENTRY_W-1:0] fifo_head;
    logic              fifo_vld;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] head_data;
    logic [IDX_W-1:0]  head_idx;

    // ------------------------------------------------------------------
    // Reader FSM.
    // The BRAM returns the word for last cycle's address and picks the
    // nibble with the live address, so src_read_addr is loaded once on
    // entry to ISSUE and held through the matching CAPTURE. It only ever
    // takes values 0..N_ELEMS-1, so a partial final word is never read
    // past the last element.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            rd_ptr_q        <= '0;
            src_read_addr_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            src_start_q     <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            src_start_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= START_SRC;
                        src_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end

                START_SRC: begin
                    state_q <= WAIT_SRC;
                end

                // src_done is only honoured here; elsewhere it is ignored.
                WAIT_SRC: begin
                    if (src_done) begin
                        rd_ptr_q        <= '0;
                        src_read_addr_q <= '0;
                        state_q         <= ISSUE;
                    end
                end

                // Only this FSM writes the FIFO and occupancy cannot grow
                // between here and CAPTURE, so checking room now is enough.
                ISSUE: begin
                    if (fifo_count < DEPTH_C) begin
                        state_q <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (rd_ptr_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end else begin
                        rd_ptr_q        <= rd_ptr_q + 1'b1;
                        src_read_addr_q <= rd_ptr_q + 1'b1;
                        state_q         <= ISSUE;
                    end
                end

                // Empty FIFO means the last element has been accepted.
                DRAIN: begin
                    if (!fifo_vld) begin
                        state_q <= DONE_ST;
                        done_q  <= 1'b1;
                    end
                end

                DONE_ST: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output buffer. Activations above ACT_MAX are saturated so a
    // misbehaving producer cannot leak out-of-range values downstream.
    // ------------------------------------------------------------------
    assign fifo_wr     = (state_q == CAPTURE);
    assign fifo_wr_dat = {act_clamp(src_read_data), rd_ptr_q};

    fmap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i    (clk),
        .reset_i  (reset),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (fifo_wr_dat),
        .rd_en_i  (m_ready),
        .rd_dat_o (fifo_head),
        .rd_vld_o (fifo_vld),
        .count_o  (fifo_count)
    );

    // Head fields are forced to zero while empty so stale storage never
    // shows on the bus (including right after reset).
    assign head_data = fifo_head[ENTRY_W-1 -: DATA_W];
    assign head_idx  = fifo_head[IDX_W-1:0];

    assign m_valid = fifo_vld;
    assign m_data  = fifo_vld ? head_data : '0;
    assign m_idx   = fifo_vld ? head_idx  : '0;
    assign m_last  = fifo_vld && (head_idx == LAST_IDX);

    assign busy          = busy_q;
    assign done          = done_q;
    assign src_start     = src_start_q;
    assign src_read_addr = src_read_addr_q;

endmodule

// File: tb/tb_conv_fmap_reader.sv
// Bench for conv_fmap_reader: full-size instance plus a 9-element instance.
// Expected stream entries are queued when a run is launched and checked on each transfer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_conv_fmap_reader;

    localparam int N_BIG   = 8192;
    localparam int N_SMALL = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // Full-size instance.
    logic        start = 1'b0, src_done = 1'b0, m_ready = 1'b1;
    logic        busy, done, src_start, m_valid, m_last;
    logic [31:0] src_read_addr, m_idx;
    logic [3:0]  m_data, src_read_data;

    // 9-element instance.
    logic        start_s = 1'b0, src_done_s = 1'b0, m_ready_s = 1'b1;
    logic        busy_s, done_s, src_start_s, m_valid_s, m_last_s;
    logic [31:0] src_read_addr_s, m_idx_s;
    logic [3:0]  m_data_s, src_read_data_s;

    conv_fmap_reader #(.N_ELEMS(N_BIG), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .src_start(src_start), .src_done(src_done),
        .src_read_addr(src_read_addr), .src_read_data(src_read_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last)
    );

    conv_fmap_reader #(.N_ELEMS(N_SMALL), .FIFO_DEPTH(4)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .busy(busy_s), .done(done_s),
        .src_start(src_start_s), .src_done(src_done_s),
        .src_read_addr(src_read_addr_s), .src_read_data(src_read_data_s),
        .m_valid(m_valid_s), .m_ready(m_ready_s), .m_data(m_data_s),
        .m_idx(m_idx_s), .m_last(m_last_s)
    );

    // Upstream BRAM model: word k = 0x0123_4560 + k, one cycle read latency,
    // nibble picked by the live address, MSB-first.
    logic [31:0] word_q = '0, word_s_q = '0;
    always @(posedge clk) begin
        word_q   <= 32'h0123_4560 + (src_read_addr >> 3);
        word_s_q <= 32'h0123_4560 + (src_read_addr_s >> 3);
    end
    assign src_read_data   = 4'((word_q   >> (28 - 4 * int'(src_read_addr[2:0])))   & 32'hF);
    assign src_read_data_s = 4'((word_s_q >> (28 - 4 * int'(src_read_addr_s[2:0]))) & 32'hF);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference entry {data, idx, last} for element i of an n-element run.
    function automatic logic [63:0] exp_ent(input int i, input int n);
        logic [31:0] w;
        logic [3:0]  nib;
        logic        lst;
        w   = 32'h0123_4560 + 32'(i / 8);
        nib = 4'((w >> (28 - 4 * (i % 8))) & 32'hF);
        if (nib > 4'd6) nib = 4'd6;
        lst = (i == n - 1);
        return {27'd0, nib, 32'(i), lst};
    endfunction

    logic [63:0] sb_q[$];
    logic [63:0] sb_s[$];
    int xfer_cnt = 0, done_cnt = 0, sstart_cnt = 0, max_addr = 0;
    int xfer_s = 0, done_cnt_s = 0, sstart_s = 0, max_addr_s = 0;

    // Monitors: a transfer is valid&&ready seen on the falling edge.
    always @(negedge clk) begin
        logic [63:0] got;
        if (done)      done_cnt++;
        if (src_start) sstart_cnt++;
        if (busy && int'(src_read_addr) > max_addr) max_addr = int'(src_read_addr);
        if (m_valid && m_ready) begin
            xfer_cnt++;
            got = {27'd0, m_data, m_idx, m_last};
            if (sb_q.size() == 0) chk("xfer_unexpected", got, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("xfer", got, sb_q.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [63:0] got;
        if (done_s)      done_cnt_s++;
        if (src_start_s) sstart_s++;
        if (busy_s && int'(src_read_addr_s) > max_addr_s) max_addr_s = int'(src_read_addr_s);
        if (m_valid_s && m_ready_s) begin
            xfer_s++;
            got = {27'd0, m_data_s, m_idx_s, m_last_s};
            if (sb_s.size() == 0) chk("s_xfer_unexpected", got, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("s_xfer", got, sb_s.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start a full-size run, queue its expected stream, answer src_start with
    // src_done and check the 3-cycle first-element latency.
    task automatic launch_big();
        max_addr = 0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("src_start_busy", 64'({src_start, busy}), 64'h3);
        cyc(1);
        chk("src_start_one_cycle", 64'({src_start, busy}), 64'h1);
        cyc(3);
        for (int i = 0; i < N_BIG; i++) sb_q.push_back(exp_ent(i, N_BIG));
        src_done = 1'b1;
        cyc(1);
        src_done = 1'b0;
        chk("lat_t1", 64'({m_valid, src_read_addr}), 64'h0);
        cyc(1);
        chk("lat_t2", 64'(m_valid), 64'h0);
        cyc(1);
        chk("lat_t3", 64'({m_valid, m_idx}), {31'd0, 1'b1, 32'd0});
    endtask

    // Wait for done; optionally pulse start every 10 cycles and inject a stray
    // src_done, or randomise m_ready. Then check run bookkeeping.
    task automatic finish_big(input string tag, input int s0, input bit spam, input bit rnd_rdy);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < 5 * N_BIG) begin
            start    = spam && (k % 10 == 0);
            src_done = spam && (k == 37);
            if (rnd_rdy) m_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
            k++;
        end
        start    = 1'b0;
        src_done = 1'b0;
        m_ready  = 1'b1;
        cyc(20);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        chk({tag, "_src_start_once"}, 64'(sstart_cnt - s0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
        chk({tag, "_max_addr"}, 64'(max_addr), 64'(N_BIG - 1));
        chk({tag, "_idle"}, 64'({busy, m_valid}), 64'd0);
    endtask

    initial begin
        int s0, d0, x0, k;

        // Reset state.
        cyc(3);
        chk("rst_flags", 64'({busy, done, src_start, m_valid, m_last}), 64'd0);
        chk("rst_addr", 64'(src_read_addr), 64'd0);
        chk("rst_head", 64'({m_data, m_idx}), 64'd0);
        reset = 1'b0;
        cyc(2);

        // src_done while idle must not start anything.
        src_done = 1'b1;
        cyc(1);
        src_done = 1'b0;
        cyc(3);
        chk("src_done_idle", 64'({busy, m_valid, src_start}), 64'd0);

        // Run A: free-running sink, repeated start pulses, stray src_done.
        s0 = sstart_cnt;
        m_ready = 1'b1;
        launch_big();
        finish_big("runA", s0, 1'b1, 1'b0);

        // Run B: backpressure from first m_valid, then reset at element 1000.
        s0 = sstart_cnt;
        m_ready = 1'b0;
        launch_big();
        cyc(50);
        chk("bp_head", {27'd0, m_data, m_idx, m_last}, exp_ent(0, N_BIG));
        chk("bp_stall", 64'({m_valid, busy, src_read_addr}), {30'd0, 2'b11, 32'd4});
        chk("bp_no_xfer", 64'(sb_q.size()), 64'(N_BIG));
        m_ready = 1'b1;
        x0 = xfer_cnt;
        k = 0;
        while (xfer_cnt - x0 < 1000 && k < 4000) begin
            cyc(1);
            k++;
        end
        chk("rB_reached_1000", 64'(xfer_cnt - x0), 64'd1000);
        d0 = done_cnt;
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midrst_flags", 64'({m_valid, busy, done, src_start, m_last}), 64'd0);
        chk("midrst_addr_head", 64'({src_read_addr, m_data}), 64'd0);
        sb_q.delete();
        cyc(30);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("midrst_no_xfer", 64'(m_valid), 64'd0);

        // Run C: fresh start after abort, random backpressure.
        s0 = sstart_cnt;
        launch_big();
        finish_big("runC", s0, 1'b0, 1'b1);

        // Short run: N_ELEMS=9, partial final word.
        s0 = sstart_s;
        d0 = done_cnt_s;
        max_addr_s = 0;
        for (int i = 0; i < N_SMALL; i++) sb_s.push_back(exp_ent(i, N_SMALL));
        start_s = 1'b1;
        cyc(1);
        start_s = 1'b0;
        cyc(3);
        src_done_s = 1'b1;
        cyc(1);
        src_done_s = 1'b0;
        k = 0;
        while (done_cnt_s == d0 && k < 300) begin
            m_ready_s = ($urandom_range(0, 1) != 0);
            cyc(1);
            k++;
        end
        m_ready_s = 1'b1;
        cyc(10);
        chk("s_done_once", 64'(done_cnt_s - d0), 64'd1);
        chk("s_src_start_once", 64'(sstart_s - s0), 64'd1);
        chk("s_xfers", 64'(xfer_s), 64'(N_SMALL));
        chk("s_max_addr", 64'(max_addr_s), 64'(N_SMALL - 1));
        chk("s_sb_empty", 64'(sb_s.size()), 64'd0);
        chk("s_idle", 64'({busy_s, m_valid_s}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compared expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
